stream_arb_mux: RTL
===================

Name: stream_arb_mux

Overview:
- Parametrised N-input valid/ready multiplexer with arbitration and one registered output stage.
- Selects one of N producers each cycle by fixed-priority or round-robin policy and forwards its WIDTH-bit payload plus source index to a single consumer.
- Sits between multiple result/request sources and one shared sink, e.g. writeback arbitration or memory-request merging.
- Generalises the combinational 2/3/4-way muxes with flow control, fairness and buffering.

Parameters:
- WIDTH, 32, payload width in bits.
- N, 4, number of input channels (1..16).
- MODE, ARB_RR, arbitration policy: ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
- SELW, max(1,$clog2(N)), index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request.
- in_data  input  N x WIDTH  per-channel payload, packed; channel i at bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; transfer on channel i when in_valid[i] & in_ready[i].
- out_valid  output  1  output register holds valid entry.
- out_data  output  WIDTH  registered payload.
- out_sel  output  SELW  index of source channel of out_data.
- out_ready  input  1  consumer accept; transfer when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync deassert by driver):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready is 0 while rst_n=0.
  - A pending output entry is discarded on reset mid-operation.
- load = (!out_valid | out_ready) & |in_valid.
- Grant, combinational, one-hot or zero:
  - ARB_FIXED: lowest index i with in_valid[i].
  - ARB_RR: first i with in_valid[i] searching rr_ptr, rr_ptr+1, ..., wrapping modulo N.
- in_ready[i] = grant[i] & (!out_valid | out_ready). At most one bit set; independent of in_valid of other channels except through grant.
- On load at edge:
  - out_valid<=1, out_data<=in_data[g], out_sel<=g.
  - ARB_RR: rr_ptr<=(g+1) mod N, with wrap from N-1 to 0.
- If out_valid & out_ready & !|in_valid: out_valid<=0. out_data/out_sel hold their last values.
- If out_valid & !out_ready: output stage stalls. out_* stable, all in_ready=0, rr_ptr unchanged.
- Latency: accepted input appears on out_* the next cycle. Throughput 1 transfer/cycle with out_ready held 1, including simultaneous output drain and input load in the same cycle.
- rr_ptr advances only on an accepted transfer, never on idle or stall cycles.
- N=1: grant=in_valid[0], out_sel=0, rr_ptr constant 0.
- Fairness (ARB_RR): with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive transfers.
- Non-requesting channels are skipped without penalty; a single requester gets back-to-back grants.
- in_data of non-granted channels is ignored. Protocol rule for sources: once valid is asserted it is held until accepted, with data stable. The block does not check this.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e.
  - function clog2_min1 for SELW.
- Sub-module arb_grant (purely combinational): inputs req[N], ptr[SELW], mode. Outputs gnt[N] one-hot and gnt_idx[SELW] plus any_gnt. Implemented via double-width masked priority encode for RR.
- stream_arb_mux holds the output register, rr_ptr and handshake logic.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately (asynchronously). After release, in_valid=4'b0001, data0=32'hA5A5_0001 -> next cycle out_valid=1, out_data=32'hA5A5_0001, out_sel=0.
- RR fairness: N=4, MODE=ARB_RR, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one transfer per cycle.
- RR skip/wrap: rr_ptr=3, in_valid=4'b0101 -> grant channel 0 (wrap), then channel 2, then 0. Channels 1 and 3 never in_ready.
- Fixed priority: MODE=ARB_FIXED, in_valid=4'b1110 for 3 transfers -> out_sel=1,1,1. Channel 3 starves by design.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data/out_sel constant, in_ready=0. Raise out_ready -> same-cycle drain and load, next channel per rr_ptr appears next cycle, no lost or duplicated word (scoreboard).
- Random: 10k cycles, random in_valid/out_ready, N=3 and N=1 -> scoreboard in-order per channel, no loss, at most one in_ready high, RR grant gap bounded by N transfers.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the stream arbiter/multiplexer.
//   arb_mode_e : arbitration policy selector (fixed priority or round-robin)
//   clog2_min1 : index width for N channels, never below one bit
package arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   function automatic int unsigned clog2_min1(input int unsigned n);
      if (n <= 32'd1) return 32'd1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational N-way grant generator.
//   req     : per-channel requests
//   ptr     : round-robin search start (ignored in fixed mode)
//   mode    : ARB_FIXED (lowest index wins) or ARB_RR
//   gnt     : one-hot grant, zero when no request
//   gnt_idx : binary index of the granted channel
//   any_gnt : at least one request present
module arb_grant
   import arb_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = clog2_min1(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  arb_mode_e       mode,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] gnt_idx,
   output logic            any_gnt
);

   logic [N-1:0]   masked;
   logic [2*N-1:0] dbl;

   // Upper half: raw requests; lower half: requests at or above ptr.
   // The lowest set bit of {req, masked} is the first requester from ptr, wrapping.
   always_comb begin
      masked  = '0;
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int i = 0; i < N; i++) begin
         masked[i] = req[i] & ((mode == ARB_RR) ? (i >= int'(ptr)) : 1'b1);
      end
      dbl = {req, masked};
      for (int i = 0; i < 2*N; i++) begin
         if (!any_gnt && dbl[i]) begin
            any_gnt = 1'b1;
            if (i < N) begin
               gnt[i]  = 1'b1;
               gnt_idx = SELW'(i);
            end else begin
               gnt[i-N] = 1'b1;
               gnt_idx  = SELW'(i - N);
            end
         end
      end
   end

endmodule

// File: rtl/stream_arb_mux.sv
// N-input valid/ready multiplexer with arbitration and a registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-channel request
//   in_data    : packed payloads, channel i at [i*WIDTH +: WIDTH]
//   in_ready   : per-channel accept (at most one bit set)
//   out_valid  : output register holds a valid entry
//   out_data   : registered payload
//   out_sel    : source channel of out_data
//   out_ready  : consumer accept
module stream_arb_mux
   import arb_pkg::*;
#(
   parameter int unsigned  WIDTH = 32,
   parameter int unsigned  N     = 4,
   parameter arb_mode_e    MODE  = ARB_RR,
   localparam int unsigned SELW  = clog2_min1(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   input  logic               out_ready
);

   logic [N-1:0]     gnt;
   logic [SELW-1:0]  gnt_idx;
   logic             any_gnt;
   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  rr_next;
   logic             space_c;
   logic             load_c;
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] ch_data [N];

   arb_grant #(.N(N), .SELW(SELW)) u_grant (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .mode    (MODE),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // Output slot is free when empty or draining this cycle.
   assign space_c  = !out_valid || out_ready;
   assign load_c   = space_c && any_gnt;
   assign in_ready = gnt & {N{space_c && rst_n}};
   assign rr_next  = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);

   // Payload of the granted channel.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) sel_data = ch_data[i];
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else if (load_c) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_sel   <= gnt_idx;
         if (MODE == ARB_RR) rr_ptr <= rr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
